// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared states, error codes, ASCII constants and hex helpers
package uart_cmd_pkg;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_PARSE   = 2'd1;
  localparam logic [1:0] ST_BUS     = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  // Error codes are held as the ASCII digit sent after 'E'; 0 means no error
  localparam logic [7:0] ERR_NONE     = 8'h00;
  localparam logic [7:0] ERR_UNKNOWN  = 8'h31;
  localparam logic [7:0] ERR_SYNTAX   = 8'h32;
  localparam logic [7:0] ERR_NON_HEX  = 8'h33;
  localparam logic [7:0] ERR_OVERFLOW = 8'h34;
  localparam logic [7:0] ERR_TIMEOUT  = 8'h35;
  localparam logic [7:0] ERR_BAD_TGT  = 8'h36;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_SP = 8'h20;

  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h61) && (c <= 8'h66)) ||
           ((c >= 8'h41) && (c <= 8'h46));
  endfunction

  // Only meaningful when is_hex(c) holds
  function automatic logic [3:0] hex2nib(input logic [7:0] c);
    logic [7:0] v;
    if (c <= 8'h39)      v = c - 8'h30;
    else if (c >= 8'h61) v = c - 8'h57;
    else                 v = c - 8'h37;
    return v[3:0];
  endfunction

  // Uppercase ASCII digit for a nibble
  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
  endfunction

endpackage

// File: rtl/uart_cmd_tx_seq.sv
// rtl/uart_cmd_tx_seq.sv - serialises a captured response buffer onto tx ready/valid
module uart_cmd_tx_seq
  import uart_cmd_pkg::*;
#(
  parameter int MAXLEN = 6,
  parameter int LW     = $clog2(MAXLEN + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [MAXLEN*8-1:0] buf_i,
  input  logic [LW-1:0]       len_i,
  output logic                tx_valid_o,
  output logic [7:0]          tx_byte_o,
  input  logic                tx_ready_i,
  output logic                done_o
);

  logic [MAXLEN*8-1:0] buf_q;
  logic [LW-1:0]       len_q;
  logic [LW-1:0]       ptr_q;
  logic                active_q;
  logic                last;

  assign last       = (ptr_q == LW'(len_q - 1'b1));
  assign done_o     = active_q & tx_ready_i & last;
  assign tx_valid_o = active_q;
  // Byte 0 sits in the low bits; output is forced to zero when idle
  assign tx_byte_o  = active_q ? buf_q[{ptr_q, 3'b000} +: 8] : 8'h00;

  // Capture the buffer on load, step the pointer on each handshake
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_q    <= '0;
      len_q    <= '0;
      ptr_q    <= '0;
      active_q <= 1'b0;
    end else if (load_i) begin
      buf_q    <= buf_i;
      len_q    <= len_i;
      ptr_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q && tx_ready_i) begin
      if (last) active_q <= 1'b0;
      else      ptr_q    <= ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_bus.sv
// rtl/uart_cmd_bus.sv - ASCII command line to bus read/write bridge with run control
module uart_cmd_bus
  import uart_cmd_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int N_TGT    = 2,
  parameter int LINE_MAX = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_byte_i,
  output logic              rx_busy_o,
  output logic              tx_valid_o,
  output logic [7:0]        tx_byte_o,
  input  logic              tx_ready_i,
  output logic [N_TGT-1:0]  bus_cs_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_rdy_i,
  output logic              run_o
);

  localparam int AD       = ADDR_W / 4;
  localparam int DD       = DATA_W / 4;
  localparam int RD_LEN   = 3 + AD;
  localparam int WR_DATA0 = 4 + AD;
  localparam int WR_LEN   = 4 + AD + DD;
  localparam int RESP_MAX = (DD + 2 > 4) ? DD + 2 : 4;
  localparam int RLW      = $clog2(RESP_MAX + 1);
  localparam int IW       = $clog2(LINE_MAX + 1);
  localparam int LIW      = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
  localparam int TW       = $clog2(TIMEOUT + 1);

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              ovf_q, ovf_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [N_TGT-1:0]  cs_q, cs_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              run_q, run_d;
  logic [7:0]        line_q [LINE_MAX];
  logic              wr_en;

  logic                  load;
  logic [RESP_MAX*8-1:0] resp_buf;
  logic [RLW-1:0]        resp_len;
  logic                  tx_done;

  logic [7:0]        cmd;
  logic [3:0]        p_tgt;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_data;
  logic              addr_hex_ok;
  logic              data_hex_ok;
  logic [7:0]        p_err;

  // Two characters followed by CR LF: "OK" and "E<n>" replies
  function automatic logic [RESP_MAX*8-1:0] short_resp(input logic [7:0] a, input logic [7:0] b);
    logic [RESP_MAX*8-1:0] r;
    r        = '0;
    r[7:0]   = a;
    r[15:8]  = b;
    r[23:16] = CH_CR;
    r[31:24] = CH_LF;
    return r;
  endfunction

  // Decode and validate the collected line; the result is only used in PARSE
  always_comb begin
    cmd         = line_q[0];
    p_tgt       = hex2nib(line_q[1]);
    addr_hex_ok = is_hex(line_q[1]);
    data_hex_ok = 1'b1;
    p_addr      = '0;
    p_data      = '0;
    for (int i = 0; i < AD; i++) begin
      addr_hex_ok = addr_hex_ok & is_hex(line_q[3+i]);
      p_addr[ADDR_W-1-4*i -: 4] = hex2nib(line_q[3+i]);
    end
    for (int i = 0; i < DD; i++) begin
      data_hex_ok = data_hex_ok & is_hex(line_q[WR_DATA0+i]);
      p_data[DATA_W-1-4*i -: 4] = hex2nib(line_q[WR_DATA0+i]);
    end
    p_err = ERR_NONE;
    if (ovf_q) begin
      p_err = ERR_OVERFLOW;
    end else if (cmd != "r" && cmd != "w" && cmd != "g" && cmd != "h") begin
      p_err = ERR_UNKNOWN;
    end else if (cmd == "r") begin
      if (idx_q != IW'(RD_LEN) || line_q[2] != CH_SP) p_err = ERR_SYNTAX;
      else if (!addr_hex_ok)                          p_err = ERR_NON_HEX;
      else if (32'(p_tgt) >= N_TGT)                   p_err = ERR_BAD_TGT;
    end else if (cmd == "w") begin
      if (idx_q != IW'(WR_LEN) || line_q[2] != CH_SP || line_q[3+AD] != CH_SP)
        p_err = ERR_SYNTAX;
      else if (!addr_hex_ok || !data_hex_ok) p_err = ERR_NON_HEX;
      else if (32'(p_tgt) >= N_TGT)          p_err = ERR_BAD_TGT;
    end else if (idx_q != IW'(1)) begin
      p_err = ERR_SYNTAX;
    end
  end

  // Command FSM: collect line, parse, run bus cycle, hand reply to the sequencer
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    tmo_d    = tmo_q;
    cs_d     = cs_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    run_d    = run_q;
    wr_en    = 1'b0;
    load     = 1'b0;
    resp_buf = '0;
    resp_len = '0;
    case (state_q)
      ST_COLLECT: begin
        if (rx_valid_i) begin
          if (rx_byte_i == CH_CR) begin
            state_d = ST_PARSE;
          end else if (rx_byte_i == CH_LF) begin
            state_d = ST_COLLECT;
          end else if (rx_byte_i == CH_BS) begin
            if (idx_q != '0) idx_d = idx_q - 1'b1;
          end else if (idx_q == IW'(LINE_MAX)) begin
            ovf_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_PARSE: begin
        if (idx_q == '0) begin
          state_d = ST_COLLECT;
        end else if (p_err != ERR_NONE) begin
          state_d  = ST_RESP;
          load     = 1'b1;
          resp_buf = short_resp("E", p_err);
          resp_len = RLW'(4);
        end else if (cmd == "g" || cmd == "h") begin
          run_d    = (cmd == "g");
          state_d  = ST_RESP;
          load     = 1'b1;
          resp_buf = short_resp("O", "K");
          resp_len = RLW'(4);
        end else begin
          state_d = ST_BUS;
          cs_d    = N_TGT'(1) << p_tgt;
          we_d    = (cmd == "w");
          addr_d  = p_addr;
          if (cmd == "w") wdata_d = p_data;
          tmo_d   = '0;
        end
      end
      ST_BUS: begin
        if (bus_rdy_i) begin
          cs_d    = '0;
          state_d = ST_RESP;
          load    = 1'b1;
          if (we_q) begin
            resp_buf = short_resp("O", "K");
            resp_len = RLW'(4);
          end else begin
            for (int i = 0; i < DD; i++)
              resp_buf[8*i +: 8] = nib2hex(bus_rdata_i[DATA_W-1-4*i -: 4]);
            resp_buf[8*DD +: 8]     = CH_CR;
            resp_buf[8*(DD+1) +: 8] = CH_LF;
            resp_len = RLW'(DD + 2);
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          cs_d     = '0;
          state_d  = ST_RESP;
          load     = 1'b1;
          resp_buf = short_resp("E", ERR_TIMEOUT);
          resp_len = RLW'(4);
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        if (tx_done) state_d = ST_COLLECT;
      end
    endcase
    if (state_d == ST_COLLECT && state_q != ST_COLLECT) begin
      idx_d = '0;
      ovf_d = 1'b0;
      tmo_d = '0;
    end
  end

  // Control and bus output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_COLLECT;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= '0;
      cs_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      run_q   <= run_d;
    end
  end

  // Line buffer storage; contents beyond the index are never interpreted
  always_ff @(posedge clk_i) begin
    if (wr_en) line_q[idx_q[LIW-1:0]] <= rx_byte_i;
  end

  uart_cmd_tx_seq #(
    .MAXLEN (RESP_MAX),
    .LW     (RLW)
  ) u_tx_seq (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .buf_i      (resp_buf),
    .len_i      (resp_len),
    .tx_valid_o (tx_valid_o),
    .tx_byte_o  (tx_byte_o),
    .tx_ready_i (tx_ready_i),
    .done_o     (tx_done)
  );

  assign rx_busy_o   = (state_q != ST_COLLECT);
  assign bus_cs_o    = cs_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign run_o       = run_q;

endmodule

// File: doc/uart_cmd_bus.md
UART_CMD_BUS -- requirements
Module: uart_cmd_bus

Interface
REQ-001 ADDR_W, default 16, bus address width; SHALL be a multiple of 4 (ADDR_W/4 hex digits).
REQ-002 DATA_W, default 16, bus data width; SHALL be a multiple of 4 (DATA_W/4 hex digits).
REQ-003 N_TGT, default 2, number of bus targets (0=ROM, 1=RAM), 1..16.
REQ-004 LINE_MAX, default 16, command line buffer depth in bytes.
REQ-005 TIMEOUT, default 255, maximum cycles to wait for bus_rdy.
REQ-006 CLK  in  1  sole clock; all logic on rising edge.
REQ-007 RST  in  1  reset, asynchronous, active-high.
REQ-008 rx_valid  in  1  single-cycle pulse; rx_byte is valid.
REQ-009 rx_byte  in  8  received character.
REQ-010 rx_busy  out  1  high whenever state is not COLLECT.
REQ-011 tx_valid  out  1  response byte available.
REQ-012 tx_byte  out  8  response character.
REQ-013 tx_ready  in  1  transmitter accepts tx_byte in this cycle.
REQ-014 bus_cs  out  N_TGT  one-hot target select.
REQ-015 bus_we  out  1  1=write, 0=read.
REQ-016 bus_addr  out  ADDR_W  address.
REQ-017 bus_wdata  out  DATA_W  write data.
REQ-018 bus_rdata  in  DATA_W  read data, valid with bus_rdy.
REQ-019 bus_rdy  in  1  target completion strobe.
REQ-020 run  out  1  system run enable.

Function
REQ-021 Command grammar, each line terminated by CR (0x0D): "r<t> <addr>", "w<t> <addr> <data>", "g", "h". <t> is one hex digit; addr and data are exactly ADDR_W/4 and DATA_W/4 hex digits; single spaces only.
REQ-022 Hex digits 0-9, a-f and A-F SHALL be accepted.
REQ-023 States SHALL be COLLECT, PARSE, BUS, RESP. Transitions: COLLECT->PARSE on CR; PARSE->BUS on a valid r/w; PARSE->RESP otherwise; BUS->RESP on bus_rdy or timeout; RESP->COLLECT after the last byte handshakes.
REQ-024 In COLLECT, a non-CR byte SHALL be stored at the index, and the index SHALL increment, saturating at LINE_MAX with an overflow flag set.
REQ-025 Backspace (0x08) SHALL decrement the index, with no change at 0.
REQ-026 LF (0x0A) SHALL be ignored.
REQ-027 rx bytes arriving outside COLLECT SHALL be dropped.
REQ-028 PARSE SHALL take exactly one cycle.
REQ-029 Error priority in PARSE: overflow E4 > unknown first char E1 > wrong length or space position E2 > non-hex digit E3 > t>=N_TGT E6.
REQ-030 In BUS: bus_cs[t], bus_we, bus_addr and bus_wdata SHALL be asserted from the first BUS cycle and held until bus_rdy, or until TIMEOUT cycles elapse, which gives E5.
REQ-031 bus_rdy SHALL be sampled only in BUS.
REQ-032 bus_cs SHALL be 0 in the cycle after exit from BUS.
REQ-033 Responses:
- read: DATA_W/4 uppercase hex digits, then CR LF
- write: "OK" CR LF
- g/h: "OK" CR LF
- error: 'E', code digit, CR LF
REQ-034 "g" SHALL set run and "h" SHALL clear run, effective on the PARSE cycle.
REQ-035 tx_valid SHALL follow ready/valid: tx_byte is stable while tx_valid=1 and tx_ready=0, and advances on the handshake.
REQ-036 An empty line (CR at index 0) SHALL produce no bus cycle and no response, and SHALL return to COLLECT.
REQ-037 Index, overflow flag and the timeout counter SHALL clear on every entry to COLLECT.

Reset
REQ-038 While RST=1, outputs SHALL be: state COLLECT, index 0, tx_valid=0, bus_cs=0, bus_we=0, bus_addr=0, bus_wdata=0, run=0, rx_busy=0.
REQ-039 RST asserted mid-bus-cycle or mid-response SHALL abort immediately, with no partial byte held.
REQ-040 On RST deassertion the block SHALL accept rx_valid from the first active edge.

Structure
REQ-041 Shared package uart_cmd_pkg SHALL hold the state encoding, error code constants, ASCII constants (CR, LF, BS, SP) and hex<->ASCII functions.
REQ-042 Sub-module uart_cmd_tx_seq SHALL serialise the response buffer onto the tx ready/valid handshake.

Verification
REQ-043 "r1 00A4" CR, then bus_rdy one cycle after BUS with bus_rdata=0x1F3C -> bus_cs=2'b10, bus_we=0, bus_addr=0x00A4; tx "1F3C" CR LF.
REQ-044 "w0 0010 BEEF" CR with tx_ready held low 5 cycles -> bus_cs=2'b01, bus_we=1, bus_wdata=0xBEEF; tx "OK" CR LF with tx_byte stable while stalled.
REQ-045 "rd" BS BS "r0 00G0" CR -> no bus cycle; tx "E3" CR LF.
REQ-046 "r1 0000" CR with bus_rdy never asserted -> bus_cs drops after 255 cycles; tx "E5" CR LF.
REQ-047 20 chars then CR -> tx "E4" CR LF; "g" CR -> run=1; RST pulsed during a response -> tx_valid=0 and run=0 asynchronously.
